// File: rtl/serial_ripple_subtractor_if.sv
// serial_ripple_subtractor_if
//   Operand/result bundle for the bit-serial subtractor.
//   Handshake rule, both directions: a transfer happens on a rising clk edge
//   where valid and ready are both 1; the sender holds its payload stable
//   while valid is 1 and ready is 0.
//   Signals:
//     a, b, bi, in_vld : operand side, driven by the producer
//     in_rd            : subtractor can take an operand set
//     d, bo, out_vld   : result side, driven by the subtractor
//     out_rd           : consumer can take the result
//   Modports: master = producer/consumer side, slave = subtractor.
interface serial_ripple_subtractor_if #(
   parameter int DATA_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic                  bi;
   logic                  in_vld;
   logic                  in_rd;
   logic [DATA_WIDTH-1:0] d;
   logic                  bo;
   logic                  out_vld;
   logic                  out_rd;

   modport master (
      output a, b, bi, in_vld, out_rd,
      input  in_rd, d, bo, out_vld
   );

   modport slave (
      input  a, b, bi, in_vld, out_rd,
      output in_rd, d, bo, out_vld
   );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor
//   Bit-serial ripple subtractor: one full-subtractor cell reused over
//   DATA_WIDTH cycles, LSB first, computing {bo, d} = a - b - bi.
//   Ports:
//     clk       : clock, rising edge
//     rst       : synchronous reset, active-high
//     bus       : operand/result handshakes (slave modport)
//     dbg_state : current FSM state (0 IDLE, 1 RUN, 2 DONE)
module serial_ripple_subtractor #(
   parameter int DATA_WIDTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   serial_ripple_subtractor_if.slave     bus,
   output logic [1:0]                    dbg_state
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] sa;
   logic [DATA_WIDTH-1:0] sb;
   logic [DATA_WIDTH-1:0] d_reg;
   logic [DATA_WIDTH-1:0] d_shift;
   logic                  br;
   logic                  br_nxt;
   logic                  diff;
   logic [CNT_W-1:0]      cnt;

   // Full-subtractor cell on the current LSBs.
   assign diff   = sa[0] ^ sb[0] ^ br;
   assign br_nxt = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);

   // New difference bit enters at the MSB; written this way so that
   // DATA_WIDTH = 1 needs no special slice.
   always_comb begin
      d_shift = d_reg >> 1;
      d_shift[DATA_WIDTH-1] = diff;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_vld) state_nxt = RUN;
         RUN:     if (cnt == LAST_BIT) state_nxt = DONE;
         DONE:    if (bus.out_rd) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         d_reg <= '0;
         br    <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (bus.in_vld) begin
                  sa  <= bus.a;
                  sb  <= bus.b;
                  br  <= bus.bi;
                  cnt <= '0;
               end
            end
            RUN: begin
               d_reg <= d_shift;
               br    <= br_nxt;
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               cnt   <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Handshake outputs decode the registered state only.
   assign bus.in_rd   = (state == IDLE);
   assign bus.out_vld = (state == DONE);
   assign bus.d       = d_reg;
   assign bus.bo      = br;
   assign dbg_state   = state;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb_serial_ripple_subtractor
//   Directed bench for the bit-serial subtractor: a 4-bit instance for the
//   main scenarios and a 1-bit instance swept exhaustively.
module tb_serial_ripple_subtractor;

   logic clk;
   logic rst;
   logic [1:0] dbg4;
   logic [1:0] dbg1;
   int n_cmp;
   int n_bad;

   serial_ripple_subtractor_if #(.DATA_WIDTH(4)) bus4 ();
   serial_ripple_subtractor_if #(.DATA_WIDTH(1)) bus1 ();

   serial_ripple_subtractor #(.DATA_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4), .dbg_state(dbg4)
   );
   serial_ripple_subtractor #(.DATA_WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // One 4-bit transaction with out_rd = 1. Returns the result, the number
   // of cycles from accept until out_vld, and how many cycles in_rd was low.
   task automatic txn4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                       output logic [3:0] d_o, output logic bo_o,
                       output int lat, output int low);
      logic got;
      got  = 1'b0;
      lat  = 0;
      low  = 0;
      d_o  = '0;
      bo_o = 1'b0;
      for (int i = 0; i < 20 && !bus4.in_rd; i++) tick();
      bus4.a = a; bus4.b = b; bus4.bi = bi; bus4.in_vld = 1'b1;
      bus4.out_rd = 1'b1;
      tick();
      bus4.in_vld = 1'b0;
      for (int i = 0; i < 30 && !bus4.in_rd; i++) begin
         low++;
         if (bus4.out_vld && !got) begin
            got  = 1'b1;
            lat  = i + 1;
            d_o  = bus4.d;
            bo_o = bus4.bo;
         end
         tick();
      end
      check("txn4_done", 32'(got), 32'd1);
   endtask

   function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic bi);
      return {1'b0, a} - {1'b0, b} - {4'b0, bi};
   endfunction

   logic [4:0] exp_q[$];

   initial begin
      logic [3:0] d_o;
      logic       bo_o;
      int         lat;
      int         low;
      logic       seen;
      int         last_acc;
      int         n_acc;
      int         cyc;
      logic [4:0] e;

      n_cmp = 0;
      n_bad = 0;
      bus4.a = '0; bus4.b = '0; bus4.bi = 1'b0; bus4.in_vld = 1'b0; bus4.out_rd = 1'b0;
      bus1.a = '0; bus1.b = '0; bus1.bi = 1'b0; bus1.in_vld = 1'b0; bus1.out_rd = 1'b0;
      rst = 1'b1;
      tick(); tick(); tick();
      rst = 1'b0;

      // ---- reset state ----
      check("rst_in_rd",   32'(bus4.in_rd),   32'd1);
      check("rst_out_vld", 32'(bus4.out_vld), 32'd0);
      check("rst_d",       32'(bus4.d),       32'd0);
      check("rst_bo",      32'(bus4.bo),      32'd0);
      check("rst_state",   32'(dbg4),         32'd0);
      check("rst_in_rd_w1", 32'(bus1.in_rd),  32'd1);

      // ---- basic transaction and timing ----
      txn4(4'd5, 4'd3, 1'b0, d_o, bo_o, lat, low);
      check("t1_lat", 32'(lat),  32'd5);
      check("t1_d",   32'(d_o),  32'd2);
      check("t1_bo",  32'(bo_o), 32'd0);
      check("t1_in_rd_low", 32'(low), 32'd5);

      // ---- directed vectors ----
      txn4(4'd3, 4'd5, 1'b0, d_o, bo_o, lat, low);
      check("t2_d", 32'(d_o), 32'hE);
      check("t2_bo", 32'(bo_o), 32'd1);
      txn4(4'd0, 4'd0, 1'b1, d_o, bo_o, lat, low);
      check("t3_d", 32'(d_o), 32'hF);
      check("t3_bo", 32'(bo_o), 32'd1);
      txn4(4'hF, 4'hF, 1'b1, d_o, bo_o, lat, low);
      check("t4_d", 32'(d_o), 32'hF);
      check("t4_bo", 32'(bo_o), 32'd1);
      txn4(4'hF, 4'h0, 1'b0, d_o, bo_o, lat, low);
      check("t5_d", 32'(d_o), 32'hF);
      check("t5_bo", 32'(bo_o), 32'd0);

      // ---- backpressure, with in_vld held high during DONE ----
      bus4.out_rd = 1'b0;
      bus4.a = 4'd9; bus4.b = 4'd4; bus4.bi = 1'b0; bus4.in_vld = 1'b1;
      tick();
      bus4.a = 4'd1; bus4.b = 4'd0;   // must not disturb the running 9 - 4
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (bus4.out_vld) seen = 1'b1;
         else tick();
      end
      check("bp_vld_seen", 32'(seen), 32'd1);
      for (int i = 0; i < 10; i++) begin
         check("bp_d",       32'(bus4.d),       32'd5);
         check("bp_bo",      32'(bus4.bo),      32'd0);
         check("bp_out_vld", 32'(bus4.out_vld), 32'd1);
         check("bp_in_rd",   32'(bus4.in_rd),   32'd0);
         tick();
      end
      check("bp_state", 32'(dbg4), 32'd2);
      bus4.out_rd = 1'b1;
      tick();
      bus4.out_rd = 1'b0;
      check("bp_rel_out_vld", 32'(bus4.out_vld), 32'd0);
      check("bp_rel_in_rd",   32'(bus4.in_rd),   32'd1);
      tick();                  // held in_vld is accepted here: 1 - 0
      bus4.in_vld = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (bus4.out_vld) seen = 1'b1;
         else tick();
      end
      check("bp2_vld_seen", 32'(seen), 32'd1);
      check("bp2_d",  32'(bus4.d),  32'd1);
      check("bp2_bo", 32'(bus4.bo), 32'd0);
      bus4.out_rd = 1'b1;
      tick();

      // ---- reset mid-RUN ----
      bus4.a = 4'd7; bus4.b = 4'd1; bus4.bi = 1'b0; bus4.in_vld = 1'b1;
      tick();
      bus4.in_vld = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_in_rd",   32'(bus4.in_rd),   32'd1);
      check("mr_d",       32'(bus4.d),       32'd0);
      check("mr_bo",      32'(bus4.bo),      32'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (bus4.out_vld) seen = 1'b1;
         tick();
      end
      check("mr_no_out_vld", 32'(seen), 32'd0);
      txn4(4'd6, 4'd6, 1'b0, d_o, bo_o, lat, low);
      check("mr_next_d",  32'(d_o),  32'd0);
      check("mr_next_bo", 32'(bo_o), 32'd0);

      // ---- back-to-back with in_vld held high ----
      bus4.out_rd = 1'b1;
      bus4.a  = 4'($urandom_range(0, 15));
      bus4.b  = 4'($urandom_range(0, 15));
      bus4.bi = 1'($urandom_range(0, 1));
      bus4.in_vld = 1'b1;
      last_acc = -1;
      n_acc = 0;
      cyc = 0;
      while (cyc < 1400 && (n_acc < 200 || exp_q.size() > 0)) begin
         if (bus4.out_vld) begin
            if (exp_q.size() == 0) check("b2b_unexpected", 32'(bus4.out_vld), 32'd0);
            else begin
               e = exp_q.pop_front();
               check("b2b_result", 32'({bus4.bo, bus4.d}), 32'(e));
            end
         end
         if (bus4.in_rd && bus4.in_vld) begin
            exp_q.push_back(ref4(bus4.a, bus4.b, bus4.bi));
            if (last_acc >= 0) check("b2b_interval", 32'(cyc - last_acc), 32'd6);
            last_acc = cyc;
            n_acc++;
         end
         tick();
         cyc++;
         if (n_acc >= 200) bus4.in_vld = 1'b0;
         bus4.a  = 4'($urandom_range(0, 15));
         bus4.b  = 4'($urandom_range(0, 15));
         bus4.bi = 1'($urandom_range(0, 1));
      end
      check("b2b_accepts", 32'(n_acc), 32'd200);
      check("b2b_drained", 32'(exp_q.size()), 32'd0);

      // ---- DATA_WIDTH = 1, exhaustive ----
      bus1.out_rd = 1'b1;
      for (int v = 0; v < 8; v++) begin
         logic [2:0] vec;
         logic [1:0] e1;
         vec = 3'(v);
         for (int i = 0; i < 10 && !bus1.in_rd; i++) tick();
         bus1.a = vec[2]; bus1.b = vec[1]; bus1.bi = vec[0]; bus1.in_vld = 1'b1;
         e1 = {1'b0, vec[2]} - {1'b0, vec[1]} - {1'b0, vec[0]};
         tick();
         bus1.in_vld = 1'b0;
         lat = 1;
         while (lat < 10 && !bus1.out_vld) begin
            tick();
            lat++;
         end
         check("w1_lat", 32'(lat), 32'd2);
         check("w1_result", 32'({bus1.bo, bus1.d}), 32'(e1));
         if (vec == 3'b011) begin
            check("w1_0m1m1_d",  32'(bus1.d),  32'd0);
            check("w1_0m1m1_bo", 32'(bus1.bo), 32'd1);
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
